// File: rtl/zc_period_averager.sv
// Average-period stage behind the doppler zero-crossing detector.
// Pairs half-period counts into periods, averages 2^L periods and tracks frequency lock.
//
// state  | meaning
// FIRST  | waiting for the first half of a period
// SECOND | first half latched; the next beat completes the period
module zc_period_averager #(
  parameter int COUNTER_SIZE = 32,
  parameter int MAX_LOG_AVG  = 8,
  parameter int LOCK_COUNT   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [3:0]              log_avg_len,
  input  logic [COUNTER_SIZE-1:0] lock_tol,
  input  logic [COUNTER_SIZE-1:0] i_tdata,
  input  logic                    i_tvalid,
  input  logic                    i_tlast,
  output logic                    i_tready,
  output logic [COUNTER_SIZE-1:0] o_tdata,
  output logic                    o_tvalid,
  output logic                    o_tlast,
  input  logic                    o_tready,
  output logic                    locked,
  output logic                    overflow
);
  localparam int AW = COUNTER_SIZE + 1 + MAX_LOG_AVG;
  localparam int WW = MAX_LOG_AVG + 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [3:0]    MAX_L    = 4'(MAX_LOG_AVG);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  typedef enum logic {FIRST, SECOND} state_t;

  state_t                  state, state_next;
  logic [AW-1:0]           acc, acc_sum, avg_full;
  logic [COUNTER_SIZE-1:0] half_a, prev, avg, diff;
  logic [COUNTER_SIZE:0]   period;
  logic [WW-1:0]           win_cnt, win_inc;
  logic [3:0]              leff, leff_in;
  logic [LW-1:0]           lock_cnt, lock_inc;
  logic                    have_prev, win_start, pair_done, result, in_tol;
  logic                    unused_tlast;

  assign i_tready     = 1'b1;
  assign o_tlast      = 1'b0;
  assign unused_tlast = i_tlast;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) state <= FIRST;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    win_start  = 1'b0;
    pair_done  = 1'b0;
    if (i_tvalid) begin
      case (state)
        FIRST: begin
          win_start  = (win_cnt == '0);
          state_next = SECOND;
        end
        SECOND: begin
          pair_done  = 1'b1;
          state_next = FIRST;
        end
        default: state_next = FIRST;
      endcase
    end
  end

  // Accumulator carries MAX_LOG_AVG bits of headroom, so only the final shift can exceed the output width.
  assign leff_in  = (log_avg_len > MAX_L) ? MAX_L : log_avg_len;
  assign period   = {1'b0, half_a} + {1'b0, i_tdata};
  assign acc_sum  = acc + AW'(period);
  assign avg_full = acc_sum >> leff;
  assign avg      = (|avg_full[AW-1:COUNTER_SIZE]) ? '1 : avg_full[COUNTER_SIZE-1:0];
  assign win_inc  = win_cnt + WW'(1);
  assign result   = pair_done && (win_inc == (WW'(1) << leff));
  assign diff     = (avg >= prev) ? (avg - prev) : (prev - avg);
  assign in_tol   = (diff <= lock_tol);
  assign lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      acc       <= '0;
      half_a    <= '0;
      win_cnt   <= '0;
      leff      <= '0;
      lock_cnt  <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (win_start) leff <= leff_in;
      if (i_tvalid && state == FIRST) half_a <= i_tdata;
      if (pair_done) begin
        if (result) begin
          acc     <= '0;
          win_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          win_cnt <= win_inc;
        end
      end
      if (result) begin
        o_tdata  <= avg;
        o_tvalid <= 1'b1;
        if (o_tvalid && !o_tready) overflow <= 1'b1;
        prev      <= avg;
        have_prev <= 1'b1;
        if (have_prev) begin
          if (in_tol) begin
            lock_cnt <= lock_inc;
            locked   <= (lock_inc == LOCK_MAX);
          end else begin
            lock_cnt <= '0;
            locked   <= 1'b0;
          end
        end
      end else if (o_tvalid && o_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule
